// File: rtl/tcp_tx_datap.sv
// Transmit datapath of the slow TCP engine: takes one scheduled flow, reads its
// state, sizes the next segment and hands a header descriptor to the assembler.
module tcp_tx_datap #(
  parameter int FLOWID_W = 3,
  parameter int TX_PTR_W = 12,
  parameter int MSS      = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sched_tx_val,
  input  logic [FLOWID_W-1:0] sched_tx_flowid,
  input  logic                sched_tx_ack_pend,
  input  logic                sched_tx_data_pend,
  output logic                sched_tx_rdy,
  output logic                state_rd_req_val,
  output logic [FLOWID_W-1:0] state_rd_req_addr,
  input  logic [31:0]         tx_seq_num_rd_resp,
  input  logic [31:0]         their_ack_num_rd_resp,
  input  logic [15:0]         our_win_rd_resp,
  input  logic [15:0]         their_win_rd_resp,
  input  logic [TX_PTR_W:0]   tx_head_ptr_rd_resp,
  input  logic [TX_PTR_W:0]   tx_tail_ptr_rd_resp,
  output logic                tx_seq_wr_val,
  output logic [FLOWID_W-1:0] tx_seq_wr_addr,
  output logic [31:0]         tx_seq_wr_data,
  output logic                pkt_val,
  input  logic                pkt_rdy,
  output logic [FLOWID_W-1:0] pkt_flowid,
  output logic [31:0]         pkt_seq_num,
  output logic [31:0]         pkt_ack_num,
  output logic [7:0]          pkt_flags,
  output logic [15:0]         pkt_win,
  output logic [TX_PTR_W-1:0] pkt_payload_addr,
  output logic [15:0]         pkt_payload_len,
  output logic                sched_upd_val,
  output logic [FLOWID_W-1:0] sched_upd_flowid,
  output logic                sched_upd_clr_ack,
  output logic                sched_upd_clr_data,
  output logic                sched_upd_set_rt
);

  localparam int PW = TX_PTR_W + 1;
  localparam logic [16:0] MSS_X = 17'(MSS);
  localparam logic [7:0] FLAG_ACK = 8'h10;
  localparam logic [7:0] FLAG_PSH = 8'h08;

  typedef enum logic [1:0] {IDLE, RD, CALC, OUT} state_e;

  function automatic logic [16:0] sat_sub(input logic [16:0] a, input logic [16:0] b);
    return (a > b) ? (a - b) : 17'd0;
  endfunction

  function automatic logic [16:0] min3(input logic [16:0] a, input logic [16:0] b,
                                       input logic [16:0] c);
    logic [16:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  state_e state_q, state_d;
  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  logic ack_pend_q, ack_pend_d;
  logic data_pend_q, data_pend_d;

  // Descriptor registers: loaded in CALC, never reset (qualified by state).
  logic [31:0]         seq_q, ack_q;
  logic [15:0]         win_q, len_q;
  logic [TX_PTR_W-1:0] addr_q;
  logic [7:0]          flags_q;

  logic [PW-1:0] sp, avail, inflight;
  logic [16:0]   avail_x, usable_x, len_x;
  logic          calc_psh;

  always_comb begin
    sp       = tx_seq_num_rd_resp[PW-1:0];
    avail    = tx_tail_ptr_rd_resp - sp;
    inflight = sp - tx_head_ptr_rd_resp;
    avail_x  = 17'(avail);
    usable_x = sat_sub({1'b0, their_win_rd_resp}, 17'(inflight));
    len_x    = min3(avail_x, usable_x, MSS_X);
    calc_psh = (len_x != 17'd0) && (len_x == avail_x);
  end

  logic rdy_s, rd_val_s, pkt_val_s, wr_val_s, upd_val_s, upd_ack_s, upd_rt_s;

  always_comb begin
    state_d     = state_q;
    flowid_d    = flowid_q;
    ack_pend_d  = ack_pend_q;
    data_pend_d = data_pend_q;
    rdy_s       = 1'b0;
    rd_val_s    = 1'b0;
    pkt_val_s   = 1'b0;
    wr_val_s    = 1'b0;
    upd_val_s   = 1'b0;
    upd_ack_s   = 1'b0;
    upd_rt_s    = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_s = 1'b1;
        if (sched_tx_val) begin
          flowid_d    = sched_tx_flowid;
          ack_pend_d  = sched_tx_ack_pend;
          data_pend_d = sched_tx_data_pend;
          state_d     = RD;
        end
      end
      RD: begin
        rd_val_s = 1'b1;
        state_d  = CALC;
      end
      CALC: begin
        if (len_x == 17'd0 && !ack_pend_q) begin
          upd_val_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        pkt_val_s = 1'b1;
        if (pkt_rdy) begin
          wr_val_s  = 1'b1;
          upd_val_s = 1'b1;
          upd_ack_s = 1'b1;
          upd_rt_s  = (len_q != 16'd0);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flowid_q    <= '0;
      ack_pend_q  <= 1'b0;
      data_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flowid_q    <= flowid_d;
      ack_pend_q  <= ack_pend_d;
      data_pend_q <= data_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CALC) begin
      seq_q   <= tx_seq_num_rd_resp;
      ack_q   <= their_ack_num_rd_resp;
      win_q   <= our_win_rd_resp;
      addr_q  <= sp[TX_PTR_W-1:0];
      len_q   <= len_x[15:0];
      flags_q <= FLAG_ACK | (calc_psh ? FLAG_PSH : 8'h00);
    end
  end

  // Data outputs are forced to zero whenever their strobe is low.
  assign sched_tx_rdy       = rdy_s;
  assign state_rd_req_val   = rd_val_s;
  assign state_rd_req_addr  = rd_val_s ? flowid_q : '0;
  assign tx_seq_wr_val      = wr_val_s;
  assign tx_seq_wr_addr     = wr_val_s ? flowid_q : '0;
  assign tx_seq_wr_data     = wr_val_s ? (seq_q + 32'(len_q)) : 32'd0;
  assign pkt_val            = pkt_val_s;
  assign pkt_flowid         = pkt_val_s ? flowid_q : '0;
  assign pkt_seq_num        = pkt_val_s ? seq_q : 32'd0;
  assign pkt_ack_num        = pkt_val_s ? ack_q : 32'd0;
  assign pkt_flags          = pkt_val_s ? flags_q : 8'd0;
  assign pkt_win            = pkt_val_s ? win_q : 16'd0;
  assign pkt_payload_addr   = pkt_val_s ? addr_q : '0;
  assign pkt_payload_len    = pkt_val_s ? len_q : 16'd0;
  assign sched_upd_val      = upd_val_s;
  assign sched_upd_flowid   = upd_val_s ? flowid_q : '0;
  assign sched_upd_clr_ack  = upd_ack_s;
  assign sched_upd_clr_data = upd_val_s & data_pend_q;
  assign sched_upd_set_rt   = upd_rt_s;

endmodule

// File: tb/tb_tcp_tx_datap.sv
// Directed bench for tcp_tx_datap: hand-computed segment sizes, flags,
// write-backs and scheduler updates across ACK, data, limit, wrap and reset cases.
module tb_tcp_tx_datap;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_tx_val, sched_tx_ack_pend, sched_tx_data_pend, sched_tx_rdy;
  logic [2:0]  sched_tx_flowid;
  logic        state_rd_req_val;
  logic [2:0]  state_rd_req_addr;
  logic [31:0] tx_seq_num_rd_resp, their_ack_num_rd_resp;
  logic [15:0] our_win_rd_resp, their_win_rd_resp;
  logic [12:0] tx_head_ptr_rd_resp, tx_tail_ptr_rd_resp;
  logic        tx_seq_wr_val;
  logic [2:0]  tx_seq_wr_addr;
  logic [31:0] tx_seq_wr_data;
  logic        pkt_val, pkt_rdy;
  logic [2:0]  pkt_flowid;
  logic [31:0] pkt_seq_num, pkt_ack_num;
  logic [7:0]  pkt_flags;
  logic [15:0] pkt_win, pkt_payload_len;
  logic [11:0] pkt_payload_addr;
  logic        sched_upd_val, sched_upd_clr_ack, sched_upd_clr_data, sched_upd_set_rt;
  logic [2:0]  sched_upd_flowid;

  always #5 clk = ~clk;

  tcp_tx_datap #(.FLOWID_W(3), .TX_PTR_W(12), .MSS(1024)) dut (
    .clk(clk), .rst(rst),
    .sched_tx_val(sched_tx_val), .sched_tx_flowid(sched_tx_flowid),
    .sched_tx_ack_pend(sched_tx_ack_pend), .sched_tx_data_pend(sched_tx_data_pend),
    .sched_tx_rdy(sched_tx_rdy),
    .state_rd_req_val(state_rd_req_val), .state_rd_req_addr(state_rd_req_addr),
    .tx_seq_num_rd_resp(tx_seq_num_rd_resp), .their_ack_num_rd_resp(their_ack_num_rd_resp),
    .our_win_rd_resp(our_win_rd_resp), .their_win_rd_resp(their_win_rd_resp),
    .tx_head_ptr_rd_resp(tx_head_ptr_rd_resp), .tx_tail_ptr_rd_resp(tx_tail_ptr_rd_resp),
    .tx_seq_wr_val(tx_seq_wr_val), .tx_seq_wr_addr(tx_seq_wr_addr),
    .tx_seq_wr_data(tx_seq_wr_data),
    .pkt_val(pkt_val), .pkt_rdy(pkt_rdy), .pkt_flowid(pkt_flowid),
    .pkt_seq_num(pkt_seq_num), .pkt_ack_num(pkt_ack_num), .pkt_flags(pkt_flags),
    .pkt_win(pkt_win), .pkt_payload_addr(pkt_payload_addr),
    .pkt_payload_len(pkt_payload_len),
    .sched_upd_val(sched_upd_val), .sched_upd_flowid(sched_upd_flowid),
    .sched_upd_clr_ack(sched_upd_clr_ack), .sched_upd_clr_data(sched_upd_clr_data),
    .sched_upd_set_rt(sched_upd_set_rt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observations from the most recent flow
  int          rd_n, pkt_n, pkt_first, unstable, wr_n, upd_n, busy;
  logic        done;
  logic [2:0]  rd_addr, p_fid, wr_addr, u_fid;
  logic [31:0] p_seq, p_ack, wr_data;
  logic [7:0]  p_flags;
  logic [15:0] p_win, p_len;
  logic [11:0] p_addr;
  logic        u_ca, u_cd, u_rt;

  task automatic set_resp(input logic [31:0] seq, input logic [31:0] tack,
                          input logic [15:0] owin, input logic [15:0] twin,
                          input logic [12:0] head, input logic [12:0] tail);
    tx_seq_num_rd_resp    = seq;
    their_ack_num_rd_resp = tack;
    our_win_rd_resp       = owin;
    their_win_rd_resp     = twin;
    tx_head_ptr_rd_resp   = head;
    tx_tail_ptr_rd_resp   = tail;
  endtask

  task automatic do_flow(input logic [2:0] fid, input logic ap, input logic dp,
                         input int stall);
    rd_n = 0; pkt_n = 0; pkt_first = -1; unstable = 0; wr_n = 0; upd_n = 0;
    busy = -1; done = 1'b0;
    @(posedge clk); #1;
    sched_tx_val = 1'b1; sched_tx_flowid = fid;
    sched_tx_ack_pend = ap; sched_tx_data_pend = dp;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      sched_tx_val = 1'b0;
      pkt_rdy = 1'b0;
      #1;
      if (sched_tx_rdy) begin
        busy = k - 1;
        done = 1'b1;
        break;
      end
      if (state_rd_req_val) begin
        rd_n++;
        rd_addr = state_rd_req_addr;
      end
      if (pkt_val) begin
        if (pkt_n == 0) begin
          pkt_first = k;
          p_fid = pkt_flowid; p_seq = pkt_seq_num; p_ack = pkt_ack_num;
          p_flags = pkt_flags; p_win = pkt_win; p_addr = pkt_payload_addr;
          p_len = pkt_payload_len;
        end else if ({pkt_flowid, pkt_seq_num, pkt_ack_num, pkt_flags, pkt_win,
                      pkt_payload_addr, pkt_payload_len} !==
                     {p_fid, p_seq, p_ack, p_flags, p_win, p_addr, p_len}) begin
          unstable++;
        end
        pkt_rdy = (pkt_n >= stall);
        pkt_n++;
      end
      #1;
      if (tx_seq_wr_val) begin
        wr_n++;
        wr_addr = tx_seq_wr_addr;
        wr_data = tx_seq_wr_data;
      end
      if (sched_upd_val) begin
        upd_n++;
        u_fid = sched_upd_flowid;
        u_ca = sched_upd_clr_ack;
        u_cd = sched_upd_clr_data;
        u_rt = sched_upd_set_rt;
      end
    end
    pkt_rdy = 1'b0;
    chk("flow_done", done, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    sched_tx_val = 1'b0; sched_tx_flowid = '0;
    sched_tx_ack_pend = 1'b0; sched_tx_data_pend = 1'b0; pkt_rdy = 1'b0;
    set_resp(32'd0, 32'd0, 16'd0, 16'd0, 13'd0, 13'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", sched_tx_rdy, 1'b1);
    chk("rst_pkt_val", pkt_val, 1'b0);
    chk("rst_rd_val", state_rd_req_val, 1'b0);
    chk("rst_wr_val", tx_seq_wr_val, 1'b0);
    chk("rst_upd_val", sched_upd_val, 1'b0);
    rst = 1'b0;

    // Pure ACK
    set_resp(32'h0000_A100, 32'h0000_5000, 16'h1000, 16'h2000, 13'h0100, 13'h0100);
    do_flow(3'd5, 1'b1, 1'b0, 0);
    chk("ack_rd_n", rd_n, 1);
    chk("ack_rd_addr", rd_addr, 3'd5);
    chk("ack_pkt_first", pkt_first, 3);
    chk("ack_pkt_n", pkt_n, 1);
    chk("ack_fid", p_fid, 3'd5);
    chk("ack_len", p_len, 16'h0000);
    chk("ack_flags", p_flags, 8'h10);
    chk("ack_seq", p_seq, 32'h0000_A100);
    chk("ack_acknum", p_ack, 32'h0000_5000);
    chk("ack_win", p_win, 16'h1000);
    chk("ack_addr", p_addr, 12'h100);
    chk("ack_wr_n", wr_n, 1);
    chk("ack_wr_addr", wr_addr, 3'd5);
    chk("ack_wr_data", wr_data, 32'h0000_A100);
    chk("ack_upd_n", upd_n, 1);
    chk("ack_upd", {u_fid, u_ca, u_cd, u_rt}, {3'd5, 1'b1, 1'b0, 1'b0});

    // Data send: whole backlog fits, PSH set
    set_resp(32'h0000_1000, 32'h0000_7777, 16'h0400, 16'hFFFF, 13'h1000, 13'h1200);
    do_flow(3'd2, 1'b0, 1'b1, 0);
    chk("dat_pkt_first", pkt_first, 3);
    chk("dat_len", p_len, 16'h0200);
    chk("dat_flags", p_flags, 8'h18);
    chk("dat_addr", p_addr, 12'h000);
    chk("dat_win", p_win, 16'h0400);
    chk("dat_wr_data", wr_data, 32'h0000_1200);
    chk("dat_upd", {u_fid, u_ca, u_cd, u_rt}, {3'd2, 1'b1, 1'b1, 1'b1});
    chk("dat_busy", busy, 3);

    // Peer window limits: avail 0x900, inflight 0x100, window 0x300
    set_resp(32'h0003_0100, 32'h0000_0001, 16'h0800, 16'h0300, 13'h0000, 13'h0A00);
    do_flow(3'd1, 1'b1, 1'b1, 0);
    chk("win_len", p_len, 16'h0200);
    chk("win_flags", p_flags, 8'h10);
    chk("win_addr", p_addr, 12'h100);
    chk("win_wr_data", wr_data, 32'h0003_0300);

    // Same flow, wide-open window: MSS limits
    set_resp(32'h0003_0100, 32'h0000_0001, 16'h0800, 16'hFFFF, 13'h0000, 13'h0A00);
    do_flow(3'd1, 1'b1, 1'b1, 0);
    chk("mss_len", p_len, 16'h0400);
    chk("mss_flags", p_flags, 8'h10);
    chk("mss_wr_data", wr_data, 32'h0003_0500);
    chk("mss_rt", u_rt, 1'b1);

    // Nothing to send: zero window, no ack pending
    set_resp(32'h0000_2000, 32'h0000_0009, 16'h0100, 16'h0000, 13'h0000, 13'h0100);
    do_flow(3'd4, 1'b0, 1'b1, 0);
    chk("nop_pkt_n", pkt_n, 0);
    chk("nop_wr_n", wr_n, 0);
    chk("nop_upd_n", upd_n, 1);
    chk("nop_upd", {u_fid, u_ca, u_cd, u_rt}, {3'd4, 1'b0, 1'b1, 1'b0});
    chk("nop_busy", busy, 2);

    // Backpressure plus pointer and sequence wrap
    set_resp(32'hFFFF_FFF0, 32'h1234_5678, 16'h0200, 16'hFFFF, 13'h1FF0, 13'h0010);
    do_flow(3'd7, 1'b1, 1'b1, 5);
    chk("wrp_pkt_n", pkt_n, 6);
    chk("wrp_unstable", unstable, 0);
    chk("wrp_len", p_len, 16'h0020);
    chk("wrp_flags", p_flags, 8'h18);
    chk("wrp_addr", p_addr, 12'hFF0);
    chk("wrp_seq", p_seq, 32'hFFFF_FFF0);
    chk("wrp_wr_n", wr_n, 1);
    chk("wrp_wr_data", wr_data, 32'h0000_0010);
    chk("wrp_upd_n", upd_n, 1);
    chk("wrp_upd", {u_fid, u_ca, u_cd, u_rt}, {3'd7, 1'b1, 1'b1, 1'b1});
    chk("wrp_busy", busy, 8);

    // Asynchronous reset while the descriptor is waiting in OUT
    set_resp(32'h0000_1000, 32'h0000_0055, 16'h0400, 16'hFFFF, 13'h1000, 13'h1200);
    @(posedge clk); #1;
    sched_tx_val = 1'b1; sched_tx_flowid = 3'd3;
    sched_tx_ack_pend = 1'b1; sched_tx_data_pend = 1'b1;
    @(posedge clk); #1;
    sched_tx_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_pkt_val_before", pkt_val, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_pkt_val", pkt_val, 1'b0);
    chk("rst_out_pkt_len", pkt_payload_len, 16'h0000);
    chk("rst_out_rdy", sched_tx_rdy, 1'b1);
    pkt_rdy = 1'b1;
    #1;
    chk("rst_out_wr_val", tx_seq_wr_val, 1'b0);
    chk("rst_out_upd_val", sched_upd_val, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    pkt_rdy = 1'b0;

    // Normal operation afterwards
    do_flow(3'd6, 1'b1, 1'b1, 0);
    chk("post_pkt_first", pkt_first, 3);
    chk("post_len", p_len, 16'h0200);
    chk("post_wr", {wr_n[3:0], wr_addr, wr_data}, {4'd1, 3'd6, 32'h0000_1200});
    chk("post_upd", {u_fid, u_ca, u_cd, u_rt}, {3'd6, 1'b1, 1'b1, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tcp_tx_datap.md
Name: tcp_tx_datap

Overview:
Transmit-side datapath of the slow TCP engine; the send-direction counterpart of the receive datapath. Takes one flow at a time from the scheduler and reads that flow's TX and RX state and TX buffer pointers. Computes the segment to send (pure ACK or data+ACK) and emits a header descriptor to the packet assembler. It then writes back the advanced sequence number and issues a scheduler update that clears the pending bits and arms retransmit.

Parameters:
FLOWID_W, 3, flow identifier width
TX_PTR_W, 12, TX payload buffer index width; all pointers are TX_PTR_W+1 bits, MSB is the wrap bit
MSS, 1024, maximum payload bytes per segment

Ports:
clk  in  1  clock
rst  in  1  reset
sched_tx_val  in  1  scheduler offers a flow
sched_tx_flowid  in  FLOWID_W  offered flow
sched_tx_ack_pend  in  1  flow has ack_pend set
sched_tx_data_pend  in  1  flow has data_pend set
sched_tx_rdy  out  1  block accepts offer
state_rd_req_val  out  1  read strobe to all flow-state memories
state_rd_req_addr  out  FLOWID_W  read address
tx_seq_num_rd_resp  in  32  our_seq_num (next byte to send)
their_ack_num_rd_resp  in  32  ack number we advertise
our_win_rd_resp  in  16  our advertised window
their_win_rd_resp  in  16  peer window
tx_head_ptr_rd_resp  in  TX_PTR_W+1  oldest unacked byte
tx_tail_ptr_rd_resp  in  TX_PTR_W+1  end of app-written data
tx_seq_wr_val  out  1  sequence write-back strobe
tx_seq_wr_addr  out  FLOWID_W  write address
tx_seq_wr_data  out  32  updated our_seq_num
pkt_val  out  1  header descriptor valid
pkt_rdy  in  1  assembler ready
pkt_flowid  out  FLOWID_W  flow
pkt_seq_num  out  32  segment sequence number
pkt_ack_num  out  32  segment ack number
pkt_flags  out  8  TCP flags
pkt_win  out  16  advertised window
pkt_payload_addr  out  TX_PTR_W  buffer start index
pkt_payload_len  out  16  payload bytes (0 = pure ACK)
sched_upd_val  out  1  scheduler update strobe
sched_upd_flowid  out  FLOWID_W  flow
sched_upd_clr_ack  out  1  clear ack_pend
sched_upd_clr_data  out  1  clear data_pend
sched_upd_set_rt  out  1  set rt_pend

Behaviour:
- One clock; asynchronous active-high reset rst. On reset: FSM to IDLE, every output 0 except sched_tx_rdy. Registered datapath values are don't-care.
- FSM states IDLE, RD, CALC, OUT.
- IDLE: sched_tx_rdy=1. On val&rdy, latch flowid, ack_pend and data_pend, then go to RD.
- RD: state_rd_req_val=1 for one cycle with state_rd_req_addr=latched flowid. Responses are valid exactly one cycle later. Go to CALC.
- CALC: capture the responses. Let sp = seq[TX_PTR_W:0]. Compute:
  - avail = (tail - sp) mod 2^(TX_PTR_W+1)
  - inflight = (sp - head) mod 2^(TX_PTR_W+1)
  - usable = their_win > inflight ? their_win - inflight : 0
  - len = min(avail, usable, MSS), computed in 17-bit arithmetic.
- CALC exit when len==0 and ack_pend==0: pulse sched_upd_val with clr_data=data_pend, clr_ack=0, set_rt=0. No packet and no write. Return to IDLE.
- CALC exit otherwise: register the descriptor and go to OUT.
- Descriptor fields: seq=seq, ack=their_ack_num, win=our_win, payload_addr=sp[TX_PTR_W-1:0], payload_len=len.
- Descriptor flags: ACK (0x10) always. PSH (0x08) is added when len>0 and len==avail.
- OUT: pkt_val=1. The descriptor is held stable until pkt_rdy. In the handshake cycle:
  - pulse tx_seq_wr_val with data seq+len (mod 2^32);
  - pulse sched_upd_val with clr_ack=1, clr_data=data_pend, set_rt=(len>0).
  - Next state is IDLE.
- Latency: offer accepted in cycle 0, read in cycle 1, calc in cycle 2, pkt_val first high in cycle 3.
- Only one flow is in flight at a time. sched_tx_rdy=0 outside IDLE.
- Wrap: pointer subtraction wraps modulo 2^(TX_PTR_W+1). The sequence number wraps modulo 2^32. A buffer wrap does not split a segment; the assembler handles address wrap.
- Zero peer window with data waiting: a pure ACK is sent only if ack_pend=1. data_pend is cleared regardless of whether a packet is sent.
- Reset mid-OUT drops the descriptor. No write and no update are issued.

Test Plan:
- Pure ACK: ack_pend=1, head=tail=seq[12:0]=0x100, their_ack=0x5000, our_win=0x1000. Expect pkt len=0, flags 0x10, seq write 0x..100 unchanged, sched update clr_ack=1, set_rt=0.
- Data send: seq=0x1000, head=0x1000, tail=0x1200, their_win=0xFFFF. Expect len=0x200, flags 0x18, seq write 0x1200, set_rt=1, pkt_val in cycle 3.
- MSS/window limit: avail=0x900, inflight=0x100, their_win=0x300. Expect len=0x200, PSH clear. With their_win=0xFFFF expect len=MSS=0x400.
- Nothing to do: ack_pend=0, data_pend=1, their_win=0. Expect no pkt_val, no write, one sched update with clr_data=1.
- Backpressure and wrap: pkt_rdy held low 5 cycles, then high; tail=0x0010, seq ptr=0x1FF0. Expect descriptor stable, len=0x20, exactly one write and one update, sched_tx_rdy low until return to IDLE.
- Async reset asserted in OUT: outputs 0 immediately, no write; next offer processed normally.
